// File: rtl/shift_issue_queue_pkg.sv
// Shared definitions for the shift issue queue.
// Contents:
//   OP_SRA / OP_ROR  : the only opcodes the queue stores
//   AMT_W, SETPIN_W  : widths of the amount and setpin fields of an entry
//   ENTRY_EXTRA_W    : bits stored per entry in addition to the operand
//   is_shift_op()    : true for the two legal opcodes
//   setpin_of()      : 1 for SRA (sign fill), 0 for ROR
package shift_issue_queue_pkg;

    localparam logic [2:0] OP_SRA = 3'b110;
    localparam logic [2:0] OP_ROR = 3'b111;

    localparam int AMT_W         = 3;
    localparam int SETPIN_W      = 1;
    localparam int ENTRY_EXTRA_W = AMT_W + SETPIN_W;

    function automatic logic is_shift_op(input logic [2:0] op);
        return (op == OP_SRA) || (op == OP_ROR);
    endfunction

    // SRA and ROR differ only in bit 0, so the shifter's sign-fill pin is its inverse.
    function automatic logic setpin_of(input logic [2:0] op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/issue_fifo_mem.sv
// Entry storage for the shift issue queue.
// DEPTH x (DATA_W+4) register array, synchronous write, asynchronous read.
// Ports:
//   clk, reset         : clock and synchronous active-high reset (clears all entries)
//   wr_en/addr/data    : write port, captured on the rising edge
//   rd_addr / rd_data  : combinational read port
module issue_fifo_mem
    import shift_issue_queue_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int W     = DATA_W + ENTRY_EXTRA_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);

    logic [W-1:0] mem_reg [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (reset) begin
                mem_reg[gi] <= '0;
            end else if (wr_en && (wr_addr == AW'(gi))) begin
                mem_reg[gi] <= wr_data;
            end
        end
    end

    assign rd_data = mem_reg[rd_addr];

endmodule

// File: rtl/shift_issue_queue.sv
// Issue queue in front of the right-shift unit (SRA / ROR only).
// Accepts requests, drops illegal opcodes with a one-cycle err pulse,
// and presents the FIFO head to the shifter.
// Ports:
//   clk, reset                : clock, synchronous active-high reset
//   in_valid/in_ready         : upstream handshake (in_ready = count < DEPTH)
//   in_data/in_amount/in_opcode : request fields
//   flush                     : discard all queued entries (pointers/count only)
//   out_valid/out_ready       : shifter handshake
//   out_data1/out_data2/out_setpin : head entry, all zero when empty
//   err                       : pulse one cycle after an illegal opcode was consumed
//   count                     : occupied entries
module shift_issue_queue
    import shift_issue_queue_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1,
    localparam int W     = DATA_W + ENTRY_EXTRA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [2:0]        in_amount,
    input  logic [2:0]        in_opcode,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data1,
    output logic [2:0]        out_data2,
    output logic              out_setpin,
    output logic              err,
    output logic [CW-1:0]     count
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    logic [CW-1:0] count_reg, count_next;
    logic          err_reg;

    logic          accept, push, pop, bad_op;
    logic [W-1:0]  wr_data;
    logic [W-1:0]  head;

    assign in_ready  = (count_reg < DEPTH_C);
    assign out_valid = (count_reg != '0);
    assign count     = count_reg;
    assign err       = err_reg;

    assign accept = in_valid && in_ready && !flush;
    assign push   = accept && is_shift_op(in_opcode);
    assign bad_op = accept && !is_shift_op(in_opcode);
    assign pop    = out_valid && out_ready && !flush;

    // Entry layout, MSB to LSB: operand, amount, setpin.
    assign wr_data = {in_data, in_amount, setpin_of(in_opcode)};

    issue_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (push),
        .wr_addr (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_addr (rd_ptr_reg),
        .rd_data (head)
    );

    // Head fields are gated by occupancy so stale storage never shows after a flush.
    assign out_data1  = out_valid ? head[W-1 -: DATA_W]     : '0;
    assign out_data2  = out_valid ? head[SETPIN_W +: AMT_W] : '0;
    assign out_setpin = out_valid ? head[0]                 : 1'b0;

    // DEPTH is a power of two, so pointer increments wrap naturally.
    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + AW'(1);
        end
        if (push && !pop) begin
            count_next = count_reg + CW'(1);
        end else if (pop && !push) begin
            count_next = count_reg - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            err_reg    <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            err_reg    <= bad_op;
        end
    end

endmodule

// File: tb/tb_shift_issue_queue.sv
module tb_shift_issue_queue;

    localparam int DATA_W = 8;
    localparam int DEPTH  = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic [2:0] in_amount = '0;
    logic [2:0] in_opcode = '0;
    logic       flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data1;
    logic [2:0] out_data2;
    logic       out_setpin;
    logic       err;
    logic [1:0] count;

    always #5 clk = ~clk;

    shift_issue_queue #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amount  (in_amount),
        .in_opcode  (in_opcode),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data1  (out_data1),
        .out_data2  (out_data2),
        .out_setpin (out_setpin),
        .err        (err),
        .count      (count)
    );

    typedef struct packed {
        logic       v;
        logic [7:0] d;
        logic [2:0] a;
        logic [2:0] op;
        logic       rdy;
        logic       fl;
        logic       rst;
        logic [1:0] exp_count;
        logic       exp_err;
    } vec_t;

    typedef struct packed {
        logic [7:0] d;
        logic [2:0] a;
        logic       s;
    } ent_t;

    ent_t q[$];
    logic exp_err_m = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // One clock of stimulus. The reference queue predicts in_ready, the popped
    // entry, and the post-edge state; table rows additionally carry fixed count/err.
    task automatic cycle(input vec_t t, input bit use_tab);
        logic exp_rdy, do_pop, do_push, do_bad, legal;
        ent_t e;
        @(negedge clk);
        in_valid  = t.v;
        in_data   = t.d;
        in_amount = t.a;
        in_opcode = t.op;
        out_ready = t.rdy;
        flush     = t.fl;
        reset     = t.rst;
        #1;
        exp_rdy = (q.size() < DEPTH);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        legal   = (t.op == 3'b110) || (t.op == 3'b111);
        do_pop  = !t.rst && !t.fl && (q.size() != 0) && t.rdy;
        do_push = !t.rst && !t.fl && t.v && exp_rdy && legal;
        do_bad  = !t.rst && !t.fl && t.v && exp_rdy && !legal;
        if (do_pop) begin
            // Scoreboard: what the shifter consumes must be the oldest pushed entry.
            e = q[0];
            chk("pop_data1", int'(out_data1), int'(e.d));
            chk("pop_data2", int'(out_data2), int'(e.a));
            chk("pop_setpin", int'(out_setpin), int'(e.s));
        end
        @(posedge clk);
        if (t.rst || t.fl) begin
            q.delete();
            exp_err_m = 1'b0;
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) q.push_back('{d: t.d, a: t.a, s: (t.op == 3'b110)});
            exp_err_m = do_bad;
        end
        #1;
        cyc++;
        $display("cyc %0d v=%0b d=%02h a=%0d op=%03b rdy=%0b fl=%0b rst=%0b -> count=%0d valid=%0b head=%02h/%0d/%0b err=%0b",
                 cyc, t.v, t.d, t.a, t.op, t.rdy, t.fl, t.rst, count, out_valid,
                 out_data1, out_data2, out_setpin, err);
        chk("count", int'(count), q.size());
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        chk("err", int'(err), int'(exp_err_m));
        chk("head_data1", int'(out_data1), (q.size() != 0) ? int'(q[0].d) : 0);
        chk("head_data2", int'(out_data2), (q.size() != 0) ? int'(q[0].a) : 0);
        chk("head_setpin", int'(out_setpin), (q.size() != 0) ? int'(q[0].s) : 0);
        if (use_tab) begin
            chk("tab_count", int'(count), int'(t.exp_count));
            chk("tab_err", int'(err), int'(t.exp_err));
        end
    endtask

    vec_t tab[16];
    vec_t r;

    initial begin
        //           v  d       a  op      rdy fl rst cnt err
        tab[0]  = '{1'b0, 8'h00, 3'd0, 3'b000, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};
        tab[1]  = '{1'b1, 8'h99, 3'd1, 3'b110, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        tab[2]  = '{1'b1, 8'hA5, 3'd2, 3'b111, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
        tab[3]  = '{1'b1, 8'h3C, 3'd4, 3'b110, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
        tab[4]  = '{1'b0, 8'h00, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
        tab[5]  = '{1'b0, 8'h00, 3'd0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0};
        tab[6]  = '{1'b1, 8'h11, 3'd5, 3'b110, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        tab[7]  = '{1'b1, 8'hC3, 3'd3, 3'b111, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0};
        tab[8]  = '{1'b1, 8'h77, 3'd6, 3'b010, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1};
        tab[9]  = '{1'b0, 8'h00, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        tab[10] = '{1'b1, 8'h22, 3'd7, 3'b110, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
        tab[11] = '{1'b1, 8'h5A, 3'd2, 3'b110, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0};
        tab[12] = '{1'b1, 8'h44, 3'd1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0};
        tab[13] = '{1'b1, 8'h55, 3'd0, 3'b110, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0};
        tab[14] = '{1'b1, 8'h66, 3'd2, 3'b110, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0};
        tab[15] = '{1'b1, 8'h01, 3'd1, 3'b000, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            cycle(tab[i], 1'b1);
            if (i == 7) begin
                chk("ror_head_data1", int'(out_data1), 'hC3);
                chk("ror_head_setpin", int'(out_setpin), 0);
            end
        end

        // Full queue offered push+pop: only the pop happens.
        cycle('{1'b1, 8'h81, 3'd1, 3'b110, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0}, 1'b1);
        cycle('{1'b1, 8'h82, 3'd2, 3'b111, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0}, 1'b1);
        cycle('{1'b1, 8'h83, 3'd3, 3'b110, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0}, 1'b1);
        chk("full_pushpop_head", int'(out_data1), 'h82);
        // Pointer wrap: push+pop at count=1 with wrapped write pointer.
        cycle('{1'b1, 8'h84, 3'd4, 3'b111, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0}, 1'b1);
        chk("wrap_head", int'(out_data1), 'h84);
        // Illegal op pulse ends after one cycle even while still requesting nothing.
        cycle('{1'b1, 8'h85, 3'd0, 3'b101, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1}, 1'b1);
        cycle('{1'b1, 8'h86, 3'd0, 3'b011, 1'b0, 1'b0, 1'b0, 2'd1, 1'b1}, 1'b1);
        cycle('{1'b0, 8'h00, 3'd0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0}, 1'b1);

        // Random traffic against the reference queue.
        for (int i = 0; i < 20; i++) begin
            r.v   = 1'($urandom_range(0, 1));
            r.d   = 8'($urandom_range(0, 255));
            r.a   = 3'($urandom_range(0, 7));
            r.op  = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7))
                                                : {2'b11, 1'($urandom_range(0, 1))};
            r.rdy = 1'($urandom_range(0, 1));
            r.fl  = ($urandom_range(0, 9) == 0);
            r.rst = 1'b0;
            r.exp_count = '0;
            r.exp_err   = 1'b0;
            cycle(r, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
